// File: rtl/miu_arbiter.sv
// rtl/miu_arbiter.sv - arbiter sharing one MIU request port among N_REQ requesters
// MIU_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round robin.
package system_widths_pkg;
    localparam int ADDR_W = 16;
endpackage

module miu_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = system_widths_pkg::ADDR_W
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ-1:0]             req_we,
    input  logic [N_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [N_REQ-1:0][7:0]        req_wdata,
    output logic [N_REQ-1:0]             req_done,
    output logic [7:0]                   req_rdata,
    output logic [N_REQ-1:0]             grant,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [7:0]                   mem_write,
    input  logic                         mem_done,
    input  logic [7:0]                   mem_read
);
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RELEASE = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [N_REQ-1:0]    req_done_q, req_done_d;
    logic [7:0]          rdata_q, rdata_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_write_q, mem_write_d;
    logic [N_REQ-1:0]    hold_q, hold_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d;
    logic [N_REQ-1:0]    elig;
    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
`ifndef MIU_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]    last_q, last_d;
`endif

    // Unknown valid or request fields never win arbitration.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = (req_valid[i] === 1'b1) && !hold_q[i]
                      && !$isunknown({req_we[i], req_addr[i], req_wdata[i]});
        end
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef MIU_ARB_FIXED_PRIO_EN
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
`else
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (int'(last_q) + k) % N_REQ;
            if (elig[idx] && !win_found) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(idx);
            end
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        req_done_d  = '0;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_write_d = mem_write_q;
        gidx_d      = gidx_q;
`ifndef MIU_ARB_FIXED_PRIO_EN
        last_d      = last_q;
`endif
        for (int i = 0; i < N_REQ; i++) begin
            hold_d[i] = hold_q[i] && (req_valid[i] === 1'b1);
        end

        case (state_q)
            IDLE: begin
                mem_req_d = 1'b0;
                grant_d   = '0;
                if (win_found) begin
                    grant_d     = N_REQ'(1) << win_idx;
                    mem_req_d   = 1'b1;
                    mem_we_d    = req_we[win_idx];
                    mem_addr_d  = req_addr[win_idx];
                    mem_write_d = req_wdata[win_idx];
                    gidx_d      = win_idx;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (mem_done) begin
                    req_done_d     = N_REQ'(1) << gidx_q;
                    if (!mem_we_q) rdata_d = mem_read;
                    mem_req_d      = 1'b0;
                    grant_d        = '0;
                    hold_d[gidx_q] = 1'b1;
`ifndef MIU_ARB_FIXED_PRIO_EN
                    last_d         = gidx_q;
`endif
                    state_d        = RELEASE;
                end
            end
            RELEASE: begin
                mem_req_d = 1'b0;
                grant_d   = '0;
                state_d   = IDLE;
            end
            default: begin
                state_d     = IDLE;
                grant_d     = '0;
                rdata_d     = '0;
                mem_req_d   = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = '0;
                mem_write_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            req_done_q  <= '0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_write_q <= '0;
            hold_q      <= '0;
            gidx_q      <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            req_done_q  <= req_done_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_write_q <= mem_write_d;
            hold_q      <= hold_d;
            gidx_q      <= gidx_d;
        end
    end

`ifndef MIU_ARB_FIXED_PRIO_EN
    // Reset to the top index so requester 0 is searched first.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) last_q <= IDX_W'(N_REQ - 1);
        else         last_q <= last_d;
    end
`endif

    assign grant     = grant_q;
    assign req_done  = req_done_q;
    assign req_rdata = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_write = mem_write_q;
endmodule
